// File: rtl/seg7_scan_monitor_if.sv
// seg7_scan_monitor_if: scanned display bus in, reassembled frame and error pulses out.
interface seg7_scan_monitor_if #(parameter int CNT_W = 8);
   logic [3:0]       an_n;
   logic [7:0]       seg;
   logic [15:0]      digits;
   logic [3:0]       signs;
   logic             frame_valid;
   logic             seg_err;
   logic             seq_err;
   logic [CNT_W-1:0] frame_count;
   modport master (output an_n, seg, input digits, signs, frame_valid, seg_err, seq_err, frame_count);
   modport slave (input an_n, seg, output digits, signs, frame_valid, seg_err, seq_err, frame_count);
endinterface

// File: rtl/seg7_scan_monitor.sv
// seg7_scan_monitor: debounces the scanned 7-segment bus, decodes digits and reassembles d3..d0 frames.
module seg7_scan_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W = 8
) (
   input logic clk,
   input logic reset,
   seg7_scan_monitor_if.slave bus
);
   typedef enum logic [1:0] {W0, W1, W2, W3} state_t;
   localparam logic [7:0] S = 8'(STABLE_CYCLES);
   logic [11:0]       in_q, in_d;
   logic [7:0]        run_q, run_d;
   logic              acc_q, acc_d;
   state_t            state_q, state_d;
   logic              frame_bad_q, frame_bad_d;
   logic [3:0][4:0]   sh_q, sh_d;
   logic [15:0]       digits_q, digits_d;
   logic [3:0]        signs_q, signs_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fv_q, fv_d, se_q, se_d, sq_q, sq_d;
   logic [3:0]        an, nib;
   logic [1:0]        dig;
   logic              bad, legal;
   always_comb begin
      nib = 4'h0;
      bad = 1'b0;
      case (in_q[6:0])
         7'b0000001: nib = 4'h0;
         7'b1001111: nib = 4'h1;
         7'b0010010: nib = 4'h2;
         7'b0000110: nib = 4'h3;
         7'b1001100: nib = 4'h4;
         7'b0100100: nib = 4'h5;
         7'b0100000: nib = 4'h6;
         7'b0001111: nib = 4'h7;
         7'b0000000: nib = 4'h8;
         7'b0001100: nib = 4'h9;
         7'b0001000: nib = 4'hA;
         7'b1100000: nib = 4'hB;
         7'b0110001: nib = 4'hC;
         7'b1000010: nib = 4'hD;
         7'b0110000: nib = 4'hE;
         7'b0111000: nib = 4'hF;
         default:    bad = 1'b1;
      endcase
   end
   assign an    = in_q[11:8];
   assign legal = (an == 4'b0111) || (an == 4'b1011) || (an == 4'b1101) || (an == 4'b1110);
   assign dig   = (an == 4'b0111) ? 2'd3 : (an == 4'b1011) ? 2'd2 : (an == 4'b1101) ? 2'd1 : 2'd0;
   always_comb begin
      in_d        = {bus.an_n, bus.seg};
      run_d       = (in_d != in_q) ? 8'd1 : (run_q == S) ? S : run_q + 8'd1;
      acc_d       = (run_d == S) && (run_q != S);
      state_d     = state_q;
      frame_bad_d = frame_bad_q;
      sh_d        = sh_q;
      digits_d    = digits_q;
      signs_d     = signs_q;
      cnt_d       = cnt_q;
      fv_d        = 1'b0;
      se_d        = 1'b0;
      sq_d        = 1'b0;
      // acc_q marks the run held in in_q as accepted; act on it this edge
      if (acc_q && an != 4'hF) begin
         if (!legal) begin
            sq_d        = 1'b1;
            state_d     = W3;
            frame_bad_d = 1'b0;
         end else begin
            se_d      = bad;
            sh_d[dig] = {~in_q[7], nib};
            if (dig == 2'(state_q)) begin
               frame_bad_d = frame_bad_q | bad;
               state_d     = (state_q == W0) ? W3 : state_t'(2'(state_q) - 2'd1);
               if (state_q == W0) begin
                  frame_bad_d = 1'b0;
                  if (!(frame_bad_q | bad)) begin
                     digits_d = {sh_q[3][3:0], sh_q[2][3:0], sh_q[1][3:0], nib};
                     signs_d  = {sh_q[3][4], sh_q[2][4], sh_q[1][4], ~in_q[7]};
                     cnt_d    = cnt_q + CNT_W'(1);
                     fv_d     = 1'b1;
                  end
               end
            end else begin
               sq_d        = 1'b1;
               state_d     = (dig == 2'd3) ? W2 : W3;
               frame_bad_d = (dig == 2'd3) ? bad : 1'b0;
            end
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_q        <= 12'hFFF;
         run_q       <= '0;
         acc_q       <= 1'b0;
         state_q     <= W3;
         frame_bad_q <= 1'b0;
         sh_q        <= '0;
         digits_q    <= '0;
         signs_q     <= '0;
         cnt_q       <= '0;
         fv_q        <= 1'b0;
         se_q        <= 1'b0;
         sq_q        <= 1'b0;
      end else begin
         in_q        <= in_d;
         run_q       <= run_d;
         acc_q       <= acc_d;
         state_q     <= state_d;
         frame_bad_q <= frame_bad_d;
         sh_q        <= sh_d;
         digits_q    <= digits_d;
         signs_q     <= signs_d;
         cnt_q       <= cnt_d;
         fv_q        <= fv_d;
         se_q        <= se_d;
         sq_q        <= sq_d;
      end
   end
   assign bus.digits      = digits_q;
   assign bus.signs       = signs_q;
   assign bus.frame_count = cnt_q;
   assign bus.frame_valid = fv_q;
   assign bus.seg_err     = se_q;
   assign bus.seq_err     = sq_q;
endmodule
